mmio_bus_ctrl: RTL

Parametrised memory-mapped I/O bus controller between the CPU's EX/DM stage and up to NUM_CH external peripherals. It replaces the single-cycle, fixed-width external `re`/`we` path with several things that path lacks: address-decoded per-channel request/acknowledge handshakes, pipeline stall generation while a peripheral is slow, and a timeout with error reporting. Accesses to the internal data-memory region pass through untouched, with no stall.

---
 rtl/mmio_pkg.sv | 20 ++
 rtl/mmio_timer.sv | 26 ++
 rtl/mmio_bus_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared types and helpers for the memory-mapped I/O bus controller.
package mmio_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   // All-ones response pattern of width w (bus widths up to 64 bits).
   function automatic logic [63:0] err_data(input int w);
      return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

   // Any of the top three address bits set selects the external I/O region.
   function automatic logic is_io(input logic [2:0] top_bits);
      return |top_bits;
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Request timeout counter: cleared outside REQ, counts while enabled.
module mmio_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mmio_bus_ctrl.sv
// MMIO bus controller: decodes CPU I/O accesses into per-channel req/ack
// handshakes, stalls the pipeline while waiting, and reports timeouts.
module mmio_bus_ctrl
   import mmio_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int NUM_CH  = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_re,
   input  logic                     cpu_we,
   input  logic [ADDR_W-1:0]        cpu_addr,
   input  logic [DATA_W-1:0]        cpu_wdata,
   output logic                     cpu_stall,
   output logic                     cpu_rvalid,
   output logic [DATA_W-1:0]        cpu_rdata,
   output logic [NUM_CH-1:0]        ch_req,
   output logic                     ch_we,
   output logic [ADDR_W-4:0]        ch_addr,
   output logic [DATA_W-1:0]        ch_wdata,
   input  logic [NUM_CH-1:0]        ch_ack,
   input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
   input  logic                     err_clr,
   output logic                     err,
   output logic [2:0]               err_ch
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);
   localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(err_data(DATA_W));

   state_t            state;
   logic [CH_W-1:0]   ch_sel;
   logic [CH_W-1:0]   ch_next;
   logic [NUM_CH-1:0] req_dec;
   logic [DATA_W-1:0] sel_rdata;
   logic              io_access;
   logic              bad_ch;
   logic              expired;

   assign io_access = (cpu_re | cpu_we) && is_io(cpu_addr[ADDR_W-1 -: 3]);
   assign ch_next   = cpu_addr[ADDR_W-4 -: CH_W];
   assign bad_ch    = {1'b0, ch_next} >= NUM_CH_L;
   assign sel_rdata = ch_rdata[ch_sel*DATA_W +: DATA_W];

   // NOTE: stall must be combinational in IDLE so the very cycle that carries
   // the access freezes the pipeline; a registered stall would arrive too late.
   assign cpu_stall = ((state == IDLE) && io_access) || (state == REQ);

   always_comb begin
      req_dec = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         req_dec[k] = (ch_next == CH_W'(k));
      end
   end

   mmio_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state != REQ),
      .en      (state == REQ),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ch_sel     <= '0;
         ch_req     <= '0;
         ch_we      <= 1'b0;
         ch_addr    <= '0;
         ch_wdata   <= '0;
         cpu_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         err        <= 1'b0;
         err_ch     <= '0;
      end else begin
         cpu_rvalid <= 1'b0;
         // Clear first so a same-cycle error set below takes precedence.
         if (err_clr) err <= 1'b0;
         case (state)
            IDLE: begin
               if (io_access) begin
                  ch_we    <= cpu_we;
                  ch_addr  <= cpu_addr[ADDR_W-4:0];
                  ch_wdata <= cpu_wdata;
                  ch_sel   <= ch_next;
                  if (bad_ch) begin
                     state      <= DONE;
                     cpu_rvalid <= 1'b1;
                     cpu_rdata  <= ERR_DATA;
                     err        <= 1'b1;
                     err_ch     <= 3'(ch_next);
                  end else begin
                     state  <= REQ;
                     ch_req <= req_dec;
                  end
               end
            end
            REQ: begin
               if (ch_ack[ch_sel]) begin
                  state      <= DONE;
                  ch_req     <= '0;
                  cpu_rvalid <= 1'b1;
                  cpu_rdata  <= sel_rdata;
               end else if (expired) begin
                  state      <= DONE;
                  ch_req     <= '0;
                  cpu_rvalid <= 1'b1;
                  cpu_rdata  <= ERR_DATA;
                  err        <= 1'b1;
                  err_ch     <= 3'(ch_sel);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
